encoded_byte_packer: RTL

Downstream sink for the histogram encoder's byte stream. Captures each `dataEncoded` byte qualified by `we`, packs eight consecutive bytes into one 64-bit word, and buffers completed words in a 4-entry FIFO behind a valid/ready output port. On `finallydone` it flushes any partial word with zero padding, then drains the FIFO and raises `done`. It also keeps running byte and saturated-byte (0xFF) counts for the mass-count readout.

---
 rtl/encoded_byte_packer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/encoded_byte_packer.sv
// Packs the encoder's byte stream into 64-bit words (first byte in [63:56]) and
// buffers them in a small FIFO behind a valid/ready port, with flush-and-drain on finallydone.
module encoded_byte_packer #(
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          we,
    input  logic [7:0]    dataEncoded,
    input  logic          finallydone,
    output logic [63:0]   word_out,
    output logic          word_valid,
    input  logic          word_ready,
    output logic [CW-1:0] byte_count,
    output logic [CW-1:0] sat_count,
    output logic          overflow,
    output logic          done,
    output logic [1:0]    fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [2:0]    idx;
    logic [63:0]   pack;
    logic [63:0]   packed_word;
    logic [5:0]    slot_lsb;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          accept;
    logic          push;
    logic          pop;
    logic          full;
    logic          do_write;
    logic [63:0]   push_word;

    // Handshake: a word transfers on every rising edge where word_valid and
    // word_ready are both high; word_valid never depends on word_ready.
    assign word_valid = (count != '0);
    assign word_out   = word_valid ? mem[rd_ptr] : '0;
    assign fsm_state  = state;

    assign accept   = (state == RUN) && we;
    assign slot_lsb = {~idx, 3'b000};
    assign pop      = word_valid && word_ready;
    assign full     = (count == FULL_COUNT);
    assign push     = (accept && (idx == 3'd7)) || ((state == FLUSH) && (idx != 3'd0));
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign do_write = push && (!full || pop);

    always_comb begin
        packed_word = pack;
        packed_word[slot_lsb +: 8] = dataEncoded;
    end

    // The pack register is cleared after every push, so unfilled slots are already zero.
    assign push_word = (state == FLUSH) ? pack : packed_word;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            state      <= RUN;
            idx        <= '0;
            pack       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            byte_count <= '0;
            sat_count  <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (accept) begin
                idx  <= idx + 3'd1;
                pack <= (idx == 3'd7) ? '0 : packed_word;
                if (byte_count != '1) begin
                    byte_count <= byte_count + 1'b1;
                end
                if ((dataEncoded == 8'hFF) && (sat_count != '1)) begin
                    sat_count <= sat_count + 1'b1;
                end
            end

            case (state)
                RUN: begin
                    if (finallydone) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    idx   <= '0;
                    pack  <= '0;
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (count == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= DONE;
                end
            endcase

            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
